// File: rtl/multipit.sv
`default_nettype none
// ============================================================================
// Module  : multipit
// Brief   : NUM_CH programmable down-counter timers sharing one prescaler,
//           each with reload, one-shot/repeat mode and sticky interrupt flag.
// Revision: 1.0 - initial release
// ============================================================================
module multipit #(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = 16,
  parameter int PRESCALE_W = 8,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  cfg_we,
  input  logic [CH_W-1:0]       cfg_ch,
  input  logic [CNT_W-1:0]      cfg_reload,
  input  logic                  cfg_repeat,
  input  logic                  cfg_start,
  input  logic [NUM_CH-1:0]     irq_ack,
  input  logic [CH_W-1:0]       rd_ch,
  output logic [CNT_W-1:0]      rd_count,
  output logic [NUM_CH-1:0]     running,
  output logic [NUM_CH-1:0]     irq_pulse,
  output logic [NUM_CH-1:0]     irq_pending,
  output logic                  irq
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ch_state_e;

  logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic                  tick;

  ch_state_e             state_q   [NUM_CH];
  ch_state_e             state_d   [NUM_CH];
  logic [CNT_W-1:0]      count_q   [NUM_CH];
  logic [CNT_W-1:0]      count_d   [NUM_CH];
  logic [CNT_W-1:0]      reload_q  [NUM_CH];
  logic [CNT_W-1:0]      reload_d  [NUM_CH];
  logic [NUM_CH-1:0]     rpt_q, rpt_d;
  logic [NUM_CH-1:0]     pulse_q, pulse_d;
  logic [NUM_CH-1:0]     pending_q, pending_d;
  logic [NUM_CH-1:0]     wr_hit;

  // A compare of >= also catches prescale being lowered below pre_cnt.
  always_comb begin
    tick      = 1'b0;
    pre_cnt_d = pre_cnt_q;
    if (enable) begin
      if (pre_cnt_q >= prescale) begin
        tick      = 1'b1;
        pre_cnt_d = '0;
      end else begin
        pre_cnt_d = pre_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      wr_hit[i] = cfg_we && (cfg_ch == CH_W'(i));
    end
  end

  // A write to a channel takes priority over its tick in the same cycle.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i]   = state_q[i];
      count_d[i]   = count_q[i];
      reload_d[i]  = reload_q[i];
      rpt_d[i]     = rpt_q[i];
      pulse_d[i]   = 1'b0;
      pending_d[i] = pending_q[i] & ~irq_ack[i];

      if (wr_hit[i]) begin
        if (cfg_start) begin
          reload_d[i] = cfg_reload;
          count_d[i]  = cfg_reload;
          rpt_d[i]    = cfg_repeat;
          state_d[i]  = (cfg_reload != '0) ? ST_RUN : ST_IDLE;
        end else begin
          state_d[i]  = ST_IDLE;
        end
      end else if (state_q[i] == ST_RUN && tick) begin
        if (count_q[i] > CNT_W'(1)) begin
          count_d[i] = count_q[i] - CNT_W'(1);
        end else begin
          pulse_d[i]   = 1'b1;
          pending_d[i] = 1'b1;
          if (rpt_q[i]) begin
            count_d[i] = reload_q[i];
          end else begin
            count_d[i] = '0;
            state_d[i] = ST_IDLE;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt_q <= '0;
      rpt_q     <= '0;
      pulse_q   <= '0;
      pending_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i]  <= ST_IDLE;
        count_q[i]  <= '0;
        reload_q[i] <= '0;
      end
    end else begin
      pre_cnt_q <= pre_cnt_d;
      rpt_q     <= rpt_d;
      pulse_q   <= pulse_d;
      pending_q <= pending_d;
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i]  <= state_d[i];
        count_q[i]  <= count_d[i];
        reload_q[i] <= reload_d[i];
      end
    end
  end

  always_comb begin
    rd_count = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      running[i] = (state_q[i] == ST_RUN);
      if (rd_ch == CH_W'(i)) begin
        rd_count = count_q[i];
      end
    end
  end

  assign irq_pulse   = pulse_q;
  assign irq_pending = pending_q;
  assign irq         = |pending_q;

endmodule
`default_nettype wire

// File: tb/tb_multipit.sv
`default_nettype none
// ============================================================================
// Module  : tb_multipit
// Brief   : Directed self-checking bench for the multipit interval timer.
// Revision: 1.0 - initial release
// ============================================================================
module tb_multipit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [7:0]  prescale;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic [15:0] cfg_reload;
  logic        cfg_repeat;
  logic        cfg_start;
  logic [3:0]  irq_ack;
  logic [1:0]  rd_ch;
  logic [15:0] rd_count;
  logic [3:0]  running;
  logic [3:0]  irq_pulse;
  logic [3:0]  irq_pending;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;
  int k;
  int first;
  int npulse;

  multipit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .prescale   (prescale),
    .cfg_we     (cfg_we),
    .cfg_ch     (cfg_ch),
    .cfg_reload (cfg_reload),
    .cfg_repeat (cfg_repeat),
    .cfg_start  (cfg_start),
    .irq_ack    (irq_ack),
    .rd_ch      (rd_ch),
    .rd_count   (rd_count),
    .running    (running),
    .irq_pulse  (irq_pulse),
    .irq_pending(irq_pending),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] ch, input logic [15:0] rl, input logic rp, input logic st);
    cfg_ch     = ch;
    cfg_reload = rl;
    cfg_repeat = rp;
    cfg_start  = st;
    cfg_we     = 1'b1;
    step();
    cfg_we     = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; enable = 1'b0; prescale = 8'd0; cfg_we = 1'b0; cfg_ch = 2'd0;
    cfg_reload = 16'd0; cfg_repeat = 1'b0; cfg_start = 1'b0; irq_ack = 4'd0; rd_ch = 2'd0;
    #2;
    check("rst_running", running, 0);
    check("rst_pending", irq_pending, 0);
    check("rst_pulse", irq_pulse, 0);
    check("rst_irq", irq, 0);
    check("rst_count", rd_count, 0);
    step(); step();
    rst_n  = 1'b1;
    enable = 1'b1;

    // Repeating ch0, reload 10, prescale 0
    wr(2'd0, 16'd10, 1'b1, 1'b1);
    check("t1_load", rd_count, 10);
    check("t1_running", running[0], 1);
    repeat (9) step();
    check("t1_cnt1", rd_count, 1);
    check("t1_nopulse", irq_pulse, 0);
    step();
    check("t1_pulse", irq_pulse, 4'b0001);
    check("t1_pending", irq_pending, 4'b0001);
    check("t1_irq", irq, 1);
    check("t1_reload", rd_count, 10);
    k = 0;
    do begin step(); k++; end while (!irq_pulse[0] && k < 30);
    check("t1_period", k, 10);

    // Ack coinciding with expiry: set wins
    repeat (9) step();
    check("t3_cnt1", rd_count, 1);
    irq_ack = 4'b0001;
    step();
    irq_ack = 4'b0000;
    check("t3_pulse", irq_pulse[0], 1);
    check("t3_pend_kept", irq_pending[0], 1);
    irq_ack = 4'b0001;
    step();
    irq_ack = 4'b0000;
    check("t3_pend_clr", irq_pending, 0);
    check("t3_irq_clr", irq, 0);
    wr(2'd0, 16'd0, 1'b0, 1'b0);
    check("t3_stop", running[0], 0);

    // Freeze with enable=0 delays one-shot expiry by 5 cycles
    wr(2'd3, 16'd8, 1'b0, 1'b1);
    rd_ch = 2'd3;
    repeat (3) step();
    check("t4_cnt5", rd_count, 5);
    enable = 1'b0;
    repeat (5) begin
      step();
      check("t4_frozen", rd_count, 5);
    end
    enable = 1'b1;
    repeat (4) step();
    check("t4_cnt1", rd_count, 1);
    check("t4_nopulse", irq_pulse, 0);
    step();
    check("t4_pulse", irq_pulse, 4'b1000);
    check("t4_idle", running[3], 0);
    check("t4_zero", rd_count, 0);
    irq_ack = 4'b1000;
    step();
    irq_ack = 4'b0000;
    check("t4_ack", irq_pending, 0);

    // One-shot ch1 with prescale 3
    prescale = 8'd3;
    wr(2'd1, 16'd2, 1'b0, 1'b1);
    rd_ch  = 2'd1;
    first  = 0;
    npulse = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (irq_pulse[1]) begin
        npulse++;
        if (first == 0) first = i;
      end
    end
    check("t2_latency", (first >= 1 && first <= 8), 1);
    check("t2_npulse", npulse, 1);
    check("t2_idle", running[1], 0);
    check("t2_zero", rd_count, 0);
    check("t2_pending", irq_pending, 4'b0010);
    prescale = 8'd0;

    // Stop ch2 mid-count, then reload=0 start=1 also idles
    wr(2'd2, 16'd50, 1'b1, 1'b1);
    rd_ch = 2'd2;
    repeat (5) step();
    check("t5_cnt45", rd_count, 45);
    wr(2'd2, 16'd7, 1'b1, 1'b0);
    check("t5_stop", running[2], 0);
    check("t5_held", rd_count, 45);
    npulse = 0;
    repeat (60) begin
      step();
      if (irq_pulse[2]) npulse++;
    end
    check("t5_nopulse", npulse, 0);
    check("t5_held2", rd_count, 45);
    wr(2'd2, 16'd5, 1'b1, 1'b1);
    step();
    wr(2'd2, 16'd0, 1'b1, 1'b1);
    check("t5_zero_idle", running[2], 0);
    check("t5_zero_cnt", rd_count, 0);

    // Write wins over expiry in the same cycle
    rd_ch = 2'd0;
    wr(2'd0, 16'd2, 1'b1, 1'b1);
    step();
    check("ww_cnt1", rd_count, 1);
    wr(2'd0, 16'd2, 1'b1, 1'b1);
    check("ww_nopulse", irq_pulse[0], 0);
    check("ww_reload", rd_count, 2);

    // Two channels expiring in the same cycle
    wr(2'd0, 16'd4, 1'b0, 1'b1);
    wr(2'd1, 16'd3, 1'b0, 1'b1);
    check("sim_cnt0", rd_count, 3);
    step(); step();
    step();
    check("sim_pulse", irq_pulse, 4'b0011);
    check("sim_pending", irq_pending, 4'b0011);
    check("sim_idle", running, 0);

    // Async reset mid-count in all channels
    for (int c = 0; c < 4; c++) wr(2'(c), 16'd100, 1'b1, 1'b1);
    repeat (10) step();
    check("t6_pre_running", running, 4'b1111);
    #3 rst_n = 1'b0;
    #1;
    check("t6_running", running, 0);
    check("t6_pending", irq_pending, 0);
    check("t6_pulse", irq_pulse, 0);
    check("t6_irq", irq, 0);
    check("t6_count", rd_count, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    npulse = 0;
    repeat (150) begin
      step();
      if (irq_pulse != 4'd0) npulse++;
    end
    check("t6_nopulse", npulse, 0);
    check("t6_still_idle", running, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
